// File: rtl/pwm_deadtime.sv
// Complementary half-bridge gate driver with programmable dead time and latched fault shutdown.
// Optional switching-event counter on Sw_cnt is built only when PWM_DEADTIME_SW_CNT_EN is defined.
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            PWM_i,
  input  logic            Enable,
  input  logic [DT_W-1:0] Dead_time,
  input  logic            Fault_n,
  input  logic            Fault_clr,
  output logic            High_o,
  output logic            Low_o,
  output logic            Fault_o,
  output logic [15:0]     Sw_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD,
    S_HIGH,
    S_LOW,
    S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cntNext;
  logic            r_pwm;
  logic            r_flt1;
  logic            r_flt2;

  // Fault_n is asynchronous; two flops bring it into the Clock domain as an active-high level.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pwm  <= 1'b0;
      r_flt1 <= 1'b0;
      r_flt2 <= 1'b0;
    end else begin
      r_pwm  <= PWM_i;
      r_flt1 <= ~Fault_n;
      r_flt2 <= r_flt1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    if (r_flt2) begin
      w_nextState = S_FAULT;
    end else if (!Enable && (r_state inside {S_DEAD, S_HIGH, S_LOW})) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Enable) begin
            w_nextState = S_DEAD;
            w_cntNext   = Dead_time;
          end
        end
        S_HIGH: begin
          if (!r_pwm) begin
            w_nextState = S_DEAD;
            w_cntNext   = Dead_time;
          end
        end
        S_LOW: begin
          if (r_pwm) begin
            w_nextState = S_DEAD;
            w_cntNext   = Dead_time;
          end
        end
        // Target side is chosen only at expiry, so PWM activity mid-gap cannot stretch it.
        S_DEAD: begin
          if (r_cnt != '0) begin
            w_cntNext = r_cnt - DT_W'(1);
          end else begin
            w_nextState = r_pwm ? S_HIGH : S_LOW;
          end
        end
        S_FAULT: begin
          if (Fault_clr) begin
            w_nextState = S_IDLE;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  // Gate outputs are decoded from the next state so they flip on the same edge as the FSM.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      High_o  <= 1'b0;
      Low_o   <= 1'b0;
      Fault_o <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
      High_o  <= (w_nextState == S_HIGH);
      Low_o   <= (w_nextState == S_LOW);
      Fault_o <= (w_nextState == S_FAULT);
    end
  end

`ifdef PWM_DEADTIME_SW_CNT_EN
  logic [15:0] r_swCnt;
  logic        w_swInc;
  logic        w_swClr;

  assign w_swInc = (r_state == S_DEAD) &&
                   ((w_nextState == S_HIGH) || (w_nextState == S_LOW));
  assign w_swClr = (r_state == S_FAULT) && (w_nextState == S_IDLE);

  // Counts completed dead-time transitions, saturating; an accepted fault clear zeroes it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_swCnt <= 16'h0000;
    end else if (w_swClr) begin
      r_swCnt <= 16'h0000;
    end else if (w_swInc && (r_swCnt != 16'hFFFF)) begin
      r_swCnt <= r_swCnt + 16'd1;
    end
  end

  assign Sw_cnt = r_swCnt;
`else
  assign Sw_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: timestamp-based reference model plus directed scenarios.
// Expectations for Sw_cnt follow PWM_DEADTIME_SW_CNT_EN when it is defined for the build.
module tb_pwm_deadtime;

  localparam int DT_W = 8;
`ifdef PWM_DEADTIME_SW_CNT_EN
  localparam bit SwEn = 1'b1;
`else
  localparam bit SwEn = 1'b0;
`endif

  logic            Clock     = 1'b0;
  logic            Reset_n   = 1'b0;
  logic            PWM_i     = 1'b0;
  logic            Enable    = 1'b0;
  logic [DT_W-1:0] Dead_time = '0;
  logic            Fault_n   = 1'b1;
  logic            Fault_clr = 1'b0;
  logic            High_o;
  logic            Low_o;
  logic            Fault_o;
  logic [15:0]     Sw_cnt;

  int total = 0;
  int bad   = 0;

  pwm_deadtime #(.DT_W(DT_W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .PWM_i     (PWM_i),
    .Enable    (Enable),
    .Dead_time (Dead_time),
    .Fault_n   (Fault_n),
    .Fault_clr (Fault_clr),
    .High_o    (High_o),
    .Low_o     (Low_o),
    .Fault_o   (Fault_o),
    .Sw_cnt    (Sw_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pwm, input logic en, input logic [DT_W-1:0] dt,
                               input logic fn, input logic fclr);
    PWM_i     = pwm;
    Enable    = en;
    Dead_time = dt;
    Fault_n   = fn;
    Fault_clr = fclr;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  // Reference model: side 0 = gap/off, 1 = high, 2 = low; a gap ends at an absolute edge number.
  int   mCycle  = 0;
  int   mGapEnd = 0;
  int   mSide   = 0;
  int   mSw     = 0;
  bit   mFault  = 0;
  bit   mActive = 0;
  bit   mPwmR   = 0;
  bit   mFltS   = 0;
  bit   mFltA   = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mCycle = 0; mGapEnd = 0; mSide = 0; mSw = 0;
      mFault = 0; mActive = 0; mPwmR = 0; mFltS = 0; mFltA = 0;
    end else begin
      mCycle++;
      if (mFltS) begin
        mFault = 1; mActive = 0; mSide = 0;
      end else if (mFault) begin
        if (Fault_clr) begin
          mFault = 0; mSw = 0;
        end
      end else if (!Enable) begin
        mActive = 0; mSide = 0;
      end else if (!mActive) begin
        mActive = 1; mSide = 0; mGapEnd = mCycle + int'(Dead_time) + 1;
      end else if (mSide == 0) begin
        if (mCycle == mGapEnd) begin
          mSide = mPwmR ? 1 : 2;
          if (mSw < 65535) mSw++;
        end
      end else if ((mSide == 1) != mPwmR) begin
        mSide = 0; mGapEnd = mCycle + int'(Dead_time) + 1;
      end
      mFltS = mFltA;
      mFltA = !Fault_n;
      mPwmR = PWM_i;
    end
  end

  always @(negedge Clock) begin
    checkOutput("model_high",  int'(High_o),  int'(mSide == 1));
    checkOutput("model_low",   int'(Low_o),   int'(mSide == 2));
    checkOutput("model_fault", int'(Fault_o), int'(mFault));
    checkOutput("model_sw",    int'(Sw_cnt),  SwEn ? mSw : 0);
    checkOutput("overlap",     int'(High_o & Low_o), 0);
  end

  initial begin
    int lowAt, highAt, lowFall, highRise, highFall, lowRise, offCnt, highSeen, faultAt;
    int ctr, edges, offRun, gaps;
    logic prevPwm;

    // Reset with arbitrary inputs, then release with Enable low.
    applyStimulus(1'b1, 1'b1, 8'd7, 1'b0, 1'b1);
    tick(3);
    checkOutput("reset_high",  int'(High_o),  0);
    checkOutput("reset_low",   int'(Low_o),   0);
    checkOutput("reset_fault", int'(Fault_o), 0);
    checkOutput("reset_sw",    int'(Sw_cnt),  0);
    applyStimulus(1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
    Reset_n = 1'b1;
    tick(4);
    checkOutput("idle_outs", int'({High_o, Low_o, Fault_o}), 0);

    // Enable with D=4 and PWM low: five off cycles, then Low_o.
    applyStimulus(1'b0, 1'b1, 8'd4, 1'b1, 1'b0);
    lowAt = -1; highSeen = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge Clock);
      if (High_o) highSeen++;
      if (lowAt < 0 && Low_o) lowAt = k;
    end
    checkOutput("enable_low_at", lowAt, 6);
    checkOutput("enable_no_high", highSeen, 0);
    checkOutput("enable_sw", int'(Sw_cnt), SwEn ? 1 : 0);
    checkOutput("pin_model_side", mSide, 2);

    // LOW to HIGH with D=4.
    PWM_i = 1'b1;
    lowFall = -1; highRise = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (lowFall < 0 && !Low_o) lowFall = k;
      if (highRise < 0 && High_o) highRise = k;
    end
    checkOutput("d4_low_fall", lowFall, 2);
    checkOutput("d4_high_rise", highRise, 7);

    // HIGH to LOW with D=0: exactly one off cycle.
    Dead_time = 8'd0;
    PWM_i = 1'b0;
    highFall = -1; lowRise = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (highFall < 0 && !High_o) highFall = k;
      if (lowRise < 0 && Low_o) lowRise = k;
    end
    checkOutput("d0_high_fall", highFall, 2);
    checkOutput("d0_low_rise", lowRise, 3);

    // D=10, two-cycle PWM pulse: gap runs 11 cycles and returns to LOW.
    Dead_time = 8'd10;
    PWM_i = 1'b1;
    offCnt = 0; highSeen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (k == 2) PWM_i = 1'b0;
      if (!High_o && !Low_o) offCnt++;
      if (High_o) highSeen++;
    end
    checkOutput("glitch_off_cycles", offCnt, 11);
    checkOutput("glitch_no_high", highSeen, 0);
    checkOutput("glitch_back_low", int'(Low_o), 1);

    // Fault from HIGH, clear ignored while active, then accepted clear.
    applyStimulus(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    tick(10);
    checkOutput("pre_fault_high", int'(High_o), 1);
    Fault_n = 1'b0;
    faultAt = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      if (faultAt < 0 && Fault_o) faultAt = k;
    end
    checkOutput("fault_at", faultAt, 3);
    checkOutput("fault_outs_off", int'(High_o | Low_o), 0);
    checkOutput("pin_model_fault", int'(mFault), 1);
    Fault_clr = 1'b1;
    tick(1);
    Fault_clr = 1'b0;
    tick(2);
    checkOutput("fault_held", int'(Fault_o), 1);
    Fault_n = 1'b1;
    tick(3);
    Fault_clr = 1'b1;
    Enable = 1'b0;
    tick(1);
    Fault_clr = 1'b0;
    checkOutput("fault_cleared", int'(Fault_o), 0);
    checkOutput("fault_clr_sw", int'(Sw_cnt), 0);
    tick(3);
    checkOutput("post_clear_idle", int'({High_o, Low_o, Fault_o}), 0);

    // Fault and Enable=0 on the same edge: fault wins.
    applyStimulus(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    tick(10);
    Fault_n = 1'b0;
    tick(2);
    Enable = 1'b0;
    tick(1);
    checkOutput("fault_beats_enable", int'(Fault_o), 1);
    Fault_n = 1'b1;
    tick(3);
    Fault_clr = 1'b1;
    tick(1);
    Fault_clr = 1'b0;
    tick(2);

    // Upstream carrier generator: counter 0..999, high below 500, D=20.
    Dead_time = 8'd20;
    Enable = 1'b1;
    ctr = 0; edges = 0; offRun = 0; gaps = 0; prevPwm = 1'b0;
    for (int cyc = 0; cyc < 10030; cyc++) begin
      PWM_i = (cyc < 10000) ? (ctr < 500) : 1'b0;
      if (cyc > 0 && PWM_i != prevPwm) edges++;
      prevPwm = PWM_i;
      ctr = (ctr + 1) % 1000;
      @(negedge Clock);
      if (!High_o && !Low_o) begin
        offRun++;
      end else if (offRun > 0) begin
        if (gaps > 0) checkOutput("gap_len", offRun, 21);
        gaps++;
        offRun = 0;
      end
    end
    checkOutput("gap_count", gaps, edges + 1);
    checkOutput("carrier_sw", int'(Sw_cnt), SwEn ? edges + 1 : 0);
    checkOutput("carrier_end_low", int'(Low_o), 1);

    // Asynchronous reset mid-operation drops outputs before the next edge.
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("async_reset", int'({High_o, Low_o, Fault_o}), 0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
